i2c_master_burst: RTL and testbench
===================================

# i2c_master_burst

Parametrised second-generation I2C bus master: runs a complete transaction (START, 7-bit address plus R/W, 0..2^LEN_W−1 data bytes, STOP) from a single start pulse. SCL is generated by a programmable divider instead of toggling every clock. Adds multi-byte burst reads and writes, per-byte ACK/NACK handling and optional slave clock stretching. Sits between the bench/host command interface and the shared SCL/SDA lines that serve the three slaves.

## Interface
- CLK_DIV, 4: clk cycles per SCL quarter-period, minimum 2; one bit period = 4·CLK_DIV cycles.
- LEN_W, 4: width of the byte-count input.
- clk  in  1  single system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  request a transaction; honoured only while busy=0.
- addr  in  7  slave address, latched at start accept.
- rw  in  1  0=write, 1=read, latched at start accept.
- len  in  LEN_W  number of data bytes, latched at start accept; 0 = address-only probe.
- tx_data  in  8  next write byte; latched in the cycle tx_load=1.
- tx_load  out  1  one-cycle pulse: tx_data latched, so the source may present the next byte.
- rx_data  out  8  last received byte, held until the next byte overwrites it.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- busy  out  1  high from start accept until done.
- done  out  1  one-cycle pulse when STOP completes.
- nack  out  1  sticky; set on address or write-byte NACK, cleared at next start accept.
- SCL_I, SDA_I  in  1  sensed bus levels.
- SCL_O, SDA_O  out  1  open-drain controls: 0 = pull low, 1 = release.

## Operation
- States: IDLE, START, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, STOP.
- IDLE: wait for start.
- IDLE→START on start; latch addr, rw and len; clear nack; busy=1 from the next cycle.
- START→ADDR.
- ADDR shifts {addr, rw} out MSB first.
- ADDR_ACK samples SDA_I:
  - 1 → set nack, go to STOP;
  - 0 with len=0 → STOP;
  - 0 with rw=0 → WRITE;
  - 0 with rw=1 → READ.
- WRITE: tx_load pulses in the first cycle of the state and the byte is latched; 8 bits are shifted out, then WRITE_ACK.
- WRITE_ACK:
  - SDA_I=1 → set nack, go to STOP;
  - otherwise decrement the remaining-byte count; 0 → STOP, else → WRITE.
- READ: SDA released; 8 bits are sampled MSB first; rx_data and rx_valid update in the cycle after the 8th sample.
- READ_ACK: master drives SDA_O=0 (ACK) if bytes remain, SDA_O=1 (NACK) on the final byte; then READ or STOP.
- STOP: on completion, done=1 and busy=0 in the same cycle; state returns to IDLE.
- start while busy=1 is ignored, with no queuing.
- Reset mid-transaction: all outputs take reset values on that edge, the bus is released immediately, no STOP is generated, and no done pulse is produced.

## Timing
- Reset values:
  - SCL_O=1, SDA_O=1;
  - busy=0, done=0, nack=0;
  - rx_data=8'h00, rx_valid=0, tx_load=0.
- Each bit is four quarters q0..q3 of CLK_DIV cycles.
- Data and ACK bits:
  - SCL_O=0 in q0 and q1, SCL_O=1 in q2 and q3;
  - SDA_O changes only at the start of q0;
  - SDA_I is sampled on the last cycle of q2.
- START bit: SCL_O=1 throughout; SDA_O=1 in q0 and q1, SDA_O=0 in q2 and q3.
- STOP bit: SDA_O=0 in q0..q2, SDA_O=1 in q3; SCL_O=0 in q0 and q1, SCL_O=1 in q2 and q3.
- Latency without stretching, for a transaction that is not NACKed: done pulses exactly (9·len+11)·4·CLK_DIV cycles after the start-accept edge.
  - 9·len = 9 bits per data byte;
  - 11 = START + 9 address/ACK bits + STOP.
- An address NACK gives 11·4·CLK_DIV cycles.
- A divider counter wraps at CLK_DIV−1 and advances the quarter; the quarter wraps from q3 to q0 and advances the bit.

## Configuration
- I2C_CLK_STRETCH_EN defined:
  - during q2 of data and ACK bits, while SCL_I=0, the divider holds and SCL_O stays 1;
  - q2 restarts its full CLK_DIV count once SCL_I=1 is seen, so the stall extends the transaction by exactly the stretch duration.
- Undefined: SCL_I is ignored and timing is purely divider-based.

## Test plan
- Write, CLK_DIV=4, addr=7'h2A, rw=0, len=1, tx_data=8'hA5, slave ACKs all → SDA bit sequence 0x54,ACK,0xA5,ACK; one tx_load; done at cycle 320; nack=0.
- Read, addr=7'h51, len=2, slave returns 8'h3C then 8'hC3 → two rx_valid pulses with those values; master ACK after byte 1 and NACK after byte 2; done at cycle 464.
- Address NACK, addr=7'h10, slave holds SDA_I=1 at ADDR_ACK → nack=1, no tx_load, STOP generated, done at cycle 176.
- Probe, len=0, slave ACKs → done at cycle 176; no tx_load and no rx_valid; a second start pulse while busy produces no effect.
- With I2C_CLK_STRETCH_EN, the slave holds SCL_I=0 for 20 cycles during bit 3 of a write → done delayed by exactly 20 cycles.
- rst=0 asserted during the 4th data bit → next edge SCL_O=1, SDA_O=1, busy=0, no done pulse; a new transaction then completes normally.

Source files
------------

// File: rtl/i2c_master_burst.sv
// i2c_master_burst: single-master I2C engine running START, address+R/W,
// 0..2^LEN_W-1 data bytes with per-byte ACK/NACK, and STOP from one start pulse.
// SCL is derived from a CLK_DIV divider (4 quarters per bit).
// Optional slave clock stretching is compiled in with `define I2C_CLK_STRETCH_EN.
module i2c_master_burst #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned LEN_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [6:0]       addr,
    input  logic             rw,
    input  logic [LEN_W-1:0] len,
    input  logic [7:0]       tx_data,
    output logic             tx_load,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic             done,
    output logic             nack,
    input  logic             SCL_I,
    input  logic             SDA_I,
    output logic             SCL_O,
    output logic             SDA_O
);

    localparam int unsigned DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [3:0] {
        IDLE, START, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, STOP
    } state_t;

    state_t           r_state;
    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_q;
    logic [2:0]       r_bit;
    logic [7:0]       r_sh;
    logic [6:0]       r_rx_sh;
    logic [LEN_W-1:0] r_rem;
    logic             r_rw;
    logic             r_samp;

    logic w_tick;
    logic w_hold;
    logic w_data_bit;

    // Quarter ends on the last divider count; data/ACK bits are the only stretchable ones
    assign w_tick     = (r_div == DIV_W'(CLK_DIV - 1));
    assign w_data_bit = (r_state != IDLE) && (r_state != START) && (r_state != STOP);

`ifdef I2C_CLK_STRETCH_EN
    // Slave holding SCL low during the high phase freezes q2 at its first count
    assign w_hold = w_data_bit && (r_q == 2'd2) && !SCL_I;
`else
    logic w_unused_scl;
    assign w_unused_scl = SCL_I;
    assign w_hold       = 1'b0;
`endif

    // Transaction FSM, bit timing and all registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_div    <= '0;
            r_q      <= 2'd0;
            r_bit    <= 3'd0;
            r_sh     <= 8'h00;
            r_rx_sh  <= 7'h00;
            r_rem    <= '0;
            r_rw     <= 1'b0;
            r_samp   <= 1'b1;
            tx_load  <= 1'b0;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            nack     <= 1'b0;
            SCL_O    <= 1'b1;
            SDA_O    <= 1'b1;
        end else begin
            tx_load  <= 1'b0;
            rx_valid <= 1'b0;
            done     <= 1'b0;
            if (r_state == IDLE) begin
                if (start) begin
                    r_state <= START;
                    r_sh    <= {addr, rw};
                    r_rw    <= rw;
                    r_rem   <= len;
                    nack    <= 1'b0;
                    busy    <= 1'b1;
                    r_div   <= '0;
                    r_q     <= 2'd0;
                    r_bit   <= 3'd0;
                end
            end else if (w_hold) begin
                r_div <= '0;
            end else if (!w_tick) begin
                r_div <= r_div + DIV_W'(1);
            end else begin
                r_div <= '0;
                // Sample point: last cycle of q2
                if (r_q == 2'd2) begin
                    r_samp <= SDA_I;
                    if (r_state == READ) begin
                        r_rx_sh <= {r_rx_sh[5:0], SDA_I};
                        if (r_bit == 3'd7) begin
                            rx_data  <= {r_rx_sh, SDA_I};
                            rx_valid <= 1'b1;
                        end
                    end
                end
                if (r_q != 2'd3) begin
                    r_q <= r_q + 2'd1;
                    if (r_q == 2'd1) begin
                        SCL_O <= 1'b1;
                        if (r_state == START) begin
                            SDA_O <= 1'b0;
                        end
                    end
                    if ((r_q == 2'd2) && (r_state == STOP)) begin
                        SDA_O <= 1'b1;
                    end
                end else begin
                    // Bit boundary: pick the next bit and its SDA level at q0
                    r_q   <= 2'd0;
                    SCL_O <= 1'b0;
                    case (r_state)
                        START: begin
                            r_state <= ADDR;
                            SDA_O   <= r_sh[7];
                            r_sh    <= {r_sh[6:0], 1'b0};
                            r_bit   <= 3'd0;
                        end
                        ADDR, WRITE: begin
                            if (r_bit == 3'd7) begin
                                r_state <= (r_state == ADDR) ? ADDR_ACK : WRITE_ACK;
                                SDA_O   <= 1'b1;
                            end else begin
                                SDA_O <= r_sh[7];
                                r_sh  <= {r_sh[6:0], 1'b0};
                                r_bit <= r_bit + 3'd1;
                            end
                        end
                        ADDR_ACK: begin
                            r_bit <= 3'd0;
                            if (r_samp) begin
                                nack    <= 1'b1;
                                r_state <= STOP;
                                SDA_O   <= 1'b0;
                            end else if (r_rem == '0) begin
                                r_state <= STOP;
                                SDA_O   <= 1'b0;
                            end else if (!r_rw) begin
                                r_state <= WRITE;
                                r_sh    <= {tx_data[6:0], 1'b0};
                                SDA_O   <= tx_data[7];
                                tx_load <= 1'b1;
                            end else begin
                                r_state <= READ;
                                SDA_O   <= 1'b1;
                            end
                        end
                        WRITE_ACK: begin
                            r_bit <= 3'd0;
                            if (r_samp) begin
                                nack    <= 1'b1;
                                r_state <= STOP;
                                SDA_O   <= 1'b0;
                            end else begin
                                r_rem <= r_rem - LEN_W'(1);
                                if (r_rem == LEN_W'(1)) begin
                                    r_state <= STOP;
                                    SDA_O   <= 1'b0;
                                end else begin
                                    r_state <= WRITE;
                                    r_sh    <= {tx_data[6:0], 1'b0};
                                    SDA_O   <= tx_data[7];
                                    tx_load <= 1'b1;
                                end
                            end
                        end
                        READ: begin
                            if (r_bit == 3'd7) begin
                                r_state <= READ_ACK;
                                SDA_O   <= (r_rem == LEN_W'(1));
                            end else begin
                                r_bit <= r_bit + 3'd1;
                            end
                        end
                        READ_ACK: begin
                            r_bit <= 3'd0;
                            r_rem <= r_rem - LEN_W'(1);
                            if (r_rem == LEN_W'(1)) begin
                                r_state <= STOP;
                                SDA_O   <= 1'b0;
                            end else begin
                                r_state <= READ;
                                SDA_O   <= 1'b1;
                            end
                        end
                        STOP: begin
                            r_state <= IDLE;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            SCL_O   <= 1'b1;
                            SDA_O   <= 1'b1;
                        end
                        default: begin
                            r_state <= IDLE;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_master_burst.sv
// Bench for i2c_master_burst: behavioural slave on a wired-AND bus, scoreboard
// of expected {byte, ack} bus words and received bytes, latency checks.
module tb_i2c_master_burst;

    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned LEN_W   = 4;
    localparam int          BIT_CYC = 4 * CLK_DIV;

    logic             clk     = 1'b0;
    logic             rst     = 1'b0;
    logic             start   = 1'b0;
    logic [6:0]       addr    = 7'h00;
    logic             rw      = 1'b0;
    logic [LEN_W-1:0] len     = '0;
    logic [7:0]       tx_data = 8'h00;
    logic             tx_load, rx_valid, busy, done, nack, SCL_O, SDA_O;
    logic [7:0]       rx_data;
    logic             scl_i, sda_i;

    logic slv_drv     = 1'b1;
    int   stretch_cnt = 0;

    assign sda_i = SDA_O & slv_drv;
    assign scl_i = SCL_O & (stretch_cnt == 0);

    i2c_master_burst #(.CLK_DIV(CLK_DIV), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .addr(addr), .rw(rw), .len(len),
        .tx_data(tx_data), .tx_load(tx_load), .rx_data(rx_data), .rx_valid(rx_valid),
        .busy(busy), .done(done), .nack(nack),
        .SCL_I(scl_i), .SDA_I(sda_i), .SCL_O(SCL_O), .SDA_O(SDA_O)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [8:0] exp_bus_q[$];
    logic [7:0] exp_rx_q[$];
    logic [7:0] tx_src_q[$];
    logic [7:0] rd_bytes[$];
    logic [7:0] txn_bytes[$];

    int  slv_rw        = 0;
    int  slv_len       = 0;
    bit  slv_addr_nack = 1'b0;
    bit  stretch_en    = 1'b0;
    int  cyc           = 0;
    int  n_tx_load     = 0;
    int  n_rx_valid    = 0;
    int  n_done        = 0;
    int  rises         = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Slave's SDA level for bus bit n (index counted from the first address bit)
    function automatic logic drive_for(input int n);
        logic [7:0] v;
        int j, b;
        if (n == 8) return slv_addr_nack;
        if (n > 8) begin
            j = (n - 9) % 9;
            b = (n - 9) / 9;
            if (slv_addr_nack || b >= slv_len) return 1'b1;
            if (slv_rw == 0) return (j == 8) ? 1'b0 : 1'b1;
            if (j == 8) return 1'b1;
            v = rd_bytes[b];
            return v[7 - j];
        end
        return 1'b1;
    endfunction

    // Behavioural slave: tracks START, counts SCL rises, checks each 9-bit word
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    logic [8:0] sh       = '0;
    always @(negedge clk) begin
        logic bus_sda;
        if (!rst) begin
            slv_drv     = 1'b1;
            rises       = 0;
            sh          = '0;
            prev_scl    = 1'b1;
            prev_sda    = 1'b1;
            stretch_cnt = 0;
        end else begin
            if (stretch_cnt > 0) stretch_cnt--;
            bus_sda = SDA_O & slv_drv;
            if (prev_scl && SCL_O && prev_sda && !bus_sda) begin
                rises = 0;
            end else if (!prev_scl && SCL_O) begin
                sh = {sh[7:0], bus_sda};
                if (rises % 9 == 8) begin
                    if (exp_bus_q.size() == 0) check_eq("bus_extra_word", 32'(sh), 32'h1FF_FFFF);
                    else check_eq("bus_word", 32'(sh), 32'(exp_bus_q.pop_front()));
                end
                if (stretch_en && rises == 12) stretch_cnt = 20;
                rises++;
            end else if (prev_scl && !SCL_O) begin
                slv_drv = drive_for(rises);
            end
            prev_scl = SCL_O;
            prev_sda = bus_sda;
        end
    end

    // Host-side monitors: byte source, received-byte scoreboard, done counter
    always @(negedge clk) begin
        if (rst) begin
            if (tx_load) begin
                n_tx_load++;
                if (tx_src_q.size() > 0) void'(tx_src_q.pop_front());
            end
            if (rx_valid) begin
                n_rx_valid++;
                if (exp_rx_q.size() == 0) check_eq("rx_extra", 32'(rx_data), 32'hFFFF);
                else check_eq("rx_data", 32'(rx_data), 32'(exp_rx_q.pop_front()));
            end
            if (done) n_done++;
        end
        tx_data = (tx_src_q.size() > 0) ? tx_src_q[0] : 8'h00;
    end

    task automatic run_txn(input string tag, input logic [6:0] a, input logic r, input int n,
                           input bit anack, input bit dup_start, input int exp_lat);
        int t0, k, limit, tl0, rv0, dn0;
        logic [7:0] b;
        exp_bus_q.push_back({a, r, anack});
        rd_bytes.delete();
        for (int i = 0; i < n; i++) begin
            b = txn_bytes[i];
            if (r) rd_bytes.push_back(b);
            else   tx_src_q.push_back(b);
            if (!anack) begin
                exp_bus_q.push_back({b, (r && i == n - 1) ? 1'b1 : 1'b0});
                if (r) exp_rx_q.push_back(b);
            end
        end
        slv_rw = r; slv_len = n; slv_addr_nack = anack;
        tl0 = n_tx_load; rv0 = n_rx_valid; dn0 = n_done;
        @(negedge clk);
        addr = a; rw = r; len = LEN_W'(n); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0 = cyc;
        check_eq({tag, "_busy"}, 32'(busy), 32'd1);
        limit = (9 * n + 11) * BIT_CYC + 200;
        k = 0;
        while (!done && k < limit) begin
            if (dup_start && k == 40) begin
                start = 1'b1; addr = 7'h7F; rw = 1'b1; len = LEN_W'(5);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        if (!done) check_eq({tag, "_timeout"}, 32'(k), 32'(exp_lat));
        check_eq({tag, "_latency"}, 32'(cyc - t0), 32'(exp_lat));
        check_eq({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        check_eq({tag, "_nack"}, 32'(nack), 32'(anack));
        repeat (30) @(negedge clk);
        check_eq({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_done_cnt"}, 32'(n_done - dn0), 32'd1);
        check_eq({tag, "_tx_load_cnt"}, 32'((n_tx_load - tl0)), 32'((r || anack) ? 0 : n));
        check_eq({tag, "_rx_valid_cnt"}, 32'((n_rx_valid - rv0)), 32'((!r || anack) ? 0 : n));
        check_eq({tag, "_bus_drain"}, 32'(exp_bus_q.size()), 32'd0);
        txn_bytes.delete();
    endtask

    initial begin
        int k, dn0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_scl", 32'(SCL_O), 32'd1);
        check_eq("rst_sda", 32'(SDA_O), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_nack", 32'(nack), 32'd0);
        check_eq("rst_rx_data", 32'(rx_data), 32'd0);
        check_eq("rst_rx_valid", 32'(rx_valid), 32'd0);
        check_eq("rst_tx_load", 32'(tx_load), 32'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        txn_bytes.push_back(8'hA5);
        run_txn("wr1", 7'h2A, 1'b0, 1, 1'b0, 1'b0, 320);

        txn_bytes.push_back(8'h3C); txn_bytes.push_back(8'hC3);
        run_txn("rd2", 7'h51, 1'b1, 2, 1'b0, 1'b0, 464);

        txn_bytes.push_back(8'h77);
        run_txn("anack", 7'h10, 1'b0, 1, 1'b1, 1'b0, 176);
        tx_src_q.delete();

        run_txn("probe", 7'h33, 1'b0, 0, 1'b0, 1'b1, 176);

        txn_bytes.push_back(8'h01); txn_bytes.push_back(8'hFE); txn_bytes.push_back(8'h5A);
        run_txn("wr3", 7'h7E, 1'b0, 3, 1'b0, 1'b0, 608);

`ifdef I2C_CLK_STRETCH_EN
        stretch_en = 1'b1;
        txn_bytes.push_back(8'hA5);
        run_txn("stretch", 7'h2A, 1'b0, 1, 1'b0, 1'b0, 340);
        stretch_en = 1'b0;
`endif

        // Abort a 2-byte write during its 4th data bit
        exp_bus_q.push_back({7'h2A, 1'b0, 1'b0});
        tx_src_q.push_back(8'h96); tx_src_q.push_back(8'h69);
        slv_rw = 0; slv_len = 2; slv_addr_nack = 1'b0;
        dn0 = n_done;
        @(negedge clk);
        addr = 7'h2A; rw = 1'b0; len = LEN_W'(2); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (rises < 13 && k < 40 * BIT_CYC) begin
            @(negedge clk);
            k++;
        end
        check_eq("abort_reach_bit4", 32'(rises >= 13), 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("abort_scl", 32'(SCL_O), 32'd1);
        check_eq("abort_sda", 32'(SDA_O), 32'd1);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        exp_bus_q.delete(); tx_src_q.delete(); exp_rx_q.delete(); rd_bytes.delete();
        rst = 1'b1;
        repeat (100) @(negedge clk);
        check_eq("abort_no_done", 32'(n_done - dn0), 32'd0);

        txn_bytes.push_back(8'hC4);
        run_txn("post_rst", 7'h2A, 1'b0, 1, 1'b0, 1'b0, 320);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
